// File: rtl/mem_responder_pkg.sv
// Shared access-size codes and responder FSM states for the memory responder.
package mem_responder_pkg;

    localparam logic [2:0] LEN_BYTE = 3'b000;
    localparam logic [2:0] LEN_HALF = 3'b001;
    localparam logic [2:0] LEN_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage with per-byte write enables, synchronous write and combinational read.
module mem_resp_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles, then performs the
// access against the word array and holds the response until the requester takes it.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wen_q, wen_d;
    logic [31:0]     addr_q, addr_d;
    logic [2:0]      len_q, len_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            a_wen, a_err, do_access, arr_we;
    logic [31:0]     a_addr, a_wdata, off, rd_word, shifted, ld_data, wr_data;
    logic [2:0]      a_len;
    logic [1:0]      lane;
    logic [3:0]      be;

    // With single-cycle latency the access happens in the accept cycle, so it must
    // use the live request instead of the latched copy.
    assign a_wen   = (LATENCY == 1) ? req_wen   : wen_q;
    assign a_addr  = (LATENCY == 1) ? req_addr  : addr_q;
    assign a_len   = (LATENCY == 1) ? req_len   : len_q;
    assign a_wdata = (LATENCY == 1) ? req_wdata : wdata_q;

    always_comb begin
        off     = a_addr - BASE_ADDR;
        lane    = off[1:0];
        a_err   = 1'b0;
        be      = 4'b0000;
        wr_data = a_wdata;
        case (a_len)
            LEN_BYTE: begin
                be      = 4'b0001 << lane;
                wr_data = {4{a_wdata[7:0]}};
            end
            LEN_HALF: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{a_wdata[15:0]}};
                a_err   = off[0];
            end
            LEN_WORD: begin
                be      = 4'b1111;
                a_err   = (lane != 2'b00);
            end
            default: a_err = 1'b1;
        endcase
        if (a_addr < BASE_ADDR || off[31:AW+2] != '0) a_err = 1'b1;

        shifted = rd_word >> {lane, 3'b000};
        case (a_len)
            LEN_BYTE: ld_data = {24'b0, shifted[7:0]};
            LEN_HALF: ld_data = {16'b0, shifted[15:0]};
            default:  ld_data = shifted;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_access) begin
            err_d   = a_err;
            rdata_d = (a_err || a_wen) ? 32'b0 : ld_data;
        end
    end

    // A reset landing on the commit edge must drop the store.
    assign arr_we = do_access & a_wen & ~a_err & rst_n;

    mem_resp_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (be),
        .addr  (off[AW+1:2]),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (latency 2, 1, 4) checked against a byte-level
// memory model with directed and random transactions.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;
    localparam int          N     = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_wen   [N];
    logic [31:0] req_addr  [N];
    logic [2:0]  req_len   [N];
    logic [31:0] req_wdata [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mdl [longint];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wen   (req_wen[g]),
            .req_addr  (req_addr[g]),
            .req_len   (req_len[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Byte-addressed reference: sizes 1/2/4 bytes, little-endian, faults by rule.
    function automatic void model(int k, logic wen, logic [31:0] addr, logic [2:0] len,
                                  logic [31:0] wd, output logic [31:0] rd, output logic err);
        longint a = longint'(addr);
        longint key;
        int size;
        rd  = 32'b0;
        err = (len > 3'd2) || (a < longint'(BASE)) || ((a - longint'(BASE)) / 4 >= DEPTH);
        if (len == 3'd1 && (a % 2) != 0) err = 1'b1;
        if (len == 3'd2 && (a % 4) != 0) err = 1'b1;
        if (err) return;
        size = 1 << len;
        for (int i = 0; i < size; i++) begin
            key = (longint'(k) << 32) + a + i;
            if (wen) mdl[key] = 8'(wd >> (8 * i));
            else     rd = rd | (32'(mdl[key]) << (8 * i));
        end
    endfunction

    task automatic issue(int k, logic wen, logic [31:0] addr, logic [2:0] len, logic [31:0] wd);
        int n = 0;
        req_valid[k] = 1'b1;
        req_wen[k]   = wen;
        req_addr[k]  = addr;
        req_len[k]   = len;
        req_wdata[k] = wd;
        while (!req_ready[k] && n < 50) begin
            tick;
            n++;
        end
        chk("accept_ready", 32'(req_ready[k]), 32'd1);
        tick;
        req_valid[k] = 1'b0;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_len[k]   = 3'($urandom);
        req_wen[k]   = 1'($urandom);
    endtask

    task automatic wait_rsp(int k);
        int lat = 1;
        while (!rsp_valid[k] && lat < 50) begin
            tick;
            lat++;
        end
        chk($sformatf("latency_dut%0d", k), 32'(lat), 32'(lat_of(k)));
    endtask

    task automatic txn(int k, logic wen, logic [31:0] addr, logic [2:0] len, logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
        logic [31:0] erd;
        logic        eerr;
        model(k, wen, addr, len, wd, erd, eerr);
        rsp_ready[k] = 1'b1;
        issue(k, wen, addr, len, wd);
        wait_rsp(k);
        rd  = rsp_rdata[k];
        err = rsp_err[k];
        chk($sformatf("rdata_dut%0d_%h", k, addr), rd, erd);
        chk($sformatf("err_dut%0d_%h", k, addr), 32'(err), 32'(eerr));
        tick;
    endtask

    initial begin
        logic [31:0] r, held;
        logic        e;
        int          start;

        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = '0;
            req_len[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
        end
        repeat (3) tick;
        for (int k = 0; k < N; k++) begin
            chk("rst_req_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("rst_rdata", rsp_rdata[k], 32'd0);
            chk("rst_err", 32'(rsp_err[k]), 32'd0);
        end
        rst_n = 1'b1;
        tick;

        for (int k = 0; k < N; k++)
            for (int w = 0; w < 32; w++) txn(k, 1'b1, BASE + 32'(4 * w), LEN_WORD, $urandom, r, e);

        // Word read/write.
        txn(0, 1'b1, 32'h8000_0010, LEN_WORD, 32'hDEAD_BEEF, r, e);
        txn(0, 1'b0, 32'h8000_0010, LEN_WORD, 32'h0, r, e);
        chk("lw_deadbeef", r, 32'hDEAD_BEEF);

        // Byte lanes.
        txn(0, 1'b1, 32'h8000_0020, LEN_WORD, 32'h0, r, e);
        txn(0, 1'b1, 32'h8000_0023, LEN_BYTE, 32'hFFFF_FFA5, r, e);
        txn(0, 1'b0, 32'h8000_0020, LEN_WORD, 32'h0, r, e);
        chk("lw_lane3", r, 32'hA500_0000);
        txn(0, 1'b0, 32'h8000_0023, LEN_BYTE, 32'h0, r, e);
        chk("lbu_lane3", r, 32'h0000_00A5);
        txn(0, 1'b0, 32'h8000_0022, LEN_HALF, 32'h0, r, e);
        chk("lhu_upper", r, 32'h0000_A500);

        // Faults.
        txn(0, 1'b1, BASE, LEN_WORD, 32'hCAFE_F00D, r, e);
        txn(0, 1'b0, 32'h8000_0002, LEN_WORD, 32'h0, r, e);
        chk("misaligned_err", 32'(e), 32'd1);
        txn(0, 1'b1, 32'h7FFF_FFFC, LEN_WORD, 32'h1111_1111, r, e);
        chk("below_base_err", 32'(e), 32'd1);
        txn(0, 1'b0, BASE, LEN_WORD, 32'h0, r, e);
        chk("word0_kept", r, 32'hCAFE_F00D);
        txn(0, 1'b0, BASE + 32'(4 * DEPTH), LEN_WORD, 32'h0, r, e);
        chk("above_top_err", 32'(e), 32'd1);
        txn(0, 1'b0, BASE, 3'b111, 32'h0, r, e);
        chk("bad_len_err", 32'(e), 32'd1);

        // Backpressure: response held while rsp_ready is low.
        model(0, 1'b0, 32'h8000_0010, LEN_WORD, 32'h0, held, e);
        rsp_ready[0] = 1'b0;
        issue(0, 1'b0, 32'h8000_0010, LEN_WORD, 32'h0);
        wait_rsp(0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_rdata", rsp_rdata[0], held);
            chk("bp_ready", 32'(req_ready[0]), 32'd0);
            tick;
        end
        rsp_ready[0] = 1'b1;
        tick;
        chk("bp_idle_ready", 32'(req_ready[0]), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid[0]), 32'd0);
        txn(0, 1'b0, 32'h8000_0020, LEN_WORD, 32'h0, r, e);

        // Reset in the commit cycle drops the store.
        txn(0, 1'b1, 32'h8000_0040, LEN_WORD, 32'h1122_3344, r, e);
        rsp_ready[0] = 1'b1;
        issue(0, 1'b1, 32'h8000_0040, LEN_WORD, 32'h1234_5678);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(rsp_valid[0]), 32'd0);
        chk("rst_mid_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_mid_rdata", rsp_rdata[0], 32'd0);
        txn(0, 1'b0, 32'h8000_0040, LEN_WORD, 32'h0, r, e);
        chk("rst_mid_prior", r, 32'h1122_3344);

        // Throughput: 8 back-to-back loads per latency setting.
        for (int k = 0; k < N; k++) begin
            start = cyc;
            for (int i = 0; i < 8; i++) txn(k, 1'b0, BASE + 32'(4 * i), LEN_WORD, 32'h0, r, e);
            chk($sformatf("throughput_dut%0d", k), 32'(cyc - start), 32'(8 * (lat_of(k) + 1)));
        end

        // Random mix including faults.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [2:0]  l;
            int          k;
            k = $urandom_range(0, N - 1);
            a = BASE + ($urandom % 128);
            case ($urandom % 10)
                0: a = BASE - 32'(1 + $urandom % 8);
                1: a = BASE + 32'(4 * DEPTH) + ($urandom % 16);
                default: ;
            endcase
            l = ($urandom % 8 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom % 3);
            txn(k, 1'($urandom), a, l, $urandom, r, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
